// File: rtl/bp_pkg.sv
// bp_pkg: shared counter type, counter encodings and saturating counter step
package bp_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    return taken ? (c == CTR_ST ? c : c + 2'd1) : (c == CTR_SNT ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB/BHT storage, one combinational read port, one training write port
module bp_table import bp_pkg::*; #(
  parameter int   XLEN     = 32,
  parameter int   ENTRIES  = 64,
  parameter ctr_t CTR_INIT = CTR_WNT,
  localparam int  IDX      = $clog2(ENTRIES),
  localparam int  TAG_W    = XLEN - IDX - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX-1:0]   rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [XLEN-1:0]  wr_target
);
  logic [ENTRIES-1:0] valid;
  ctr_t               ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [XLEN-1:0]    target [ENTRIES];
  logic               wr_hit;
  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag[rd_idx];
  assign rd_target = target[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  assign wr_hit    = valid[wr_idx] && tag[wr_idx] == wr_tag;
  // valid and counters: train on a tag hit, allocate weakly-taken on a taken miss
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (wr_en && (wr_hit || wr_taken)) begin
      valid[wr_idx] <= 1'b1;
      ctr[wr_idx]   <= wr_hit ? ctr_next(ctr[wr_idx], wr_taken) : CTR_WT;
    end
  // tag and target only change on taken resolutions; rewriting a matching tag is harmless
  always_ff @(posedge clk)
    if (wr_en && wr_taken) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage BTB + 2-bit counter predictor with bimodal/gshare indexing and mispredict redirect
module branch_predictor import bp_pkg::*; #(
  parameter int   XLEN     = 32,
  parameter int   ENTRIES  = 64,
  parameter int   GHR_BITS = 0,
  parameter ctr_t CTR_INIT = CTR_WNT,
  parameter int   CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            PCF,
  output logic                       PredTakenF,
  output logic [XLEN-1:0]            PredTargetF,
  output logic [$clog2(ENTRIES)-1:0] PredIdxF,
  input  logic                       UpdateE,
  input  logic                       FlushE,
  input  logic [XLEN-1:0]            PCE,
  input  logic [$clog2(ENTRIES)-1:0] PredIdxE,
  input  logic                       PredTakenE,
  input  logic [XLEN-1:0]            PredTargetE,
  input  logic                       BranchTakenE,
  input  logic [XLEN-1:0]            BranchTargetE,
  output logic                       MispredictE,
  output logic [XLEN-1:0]            CorrectPCE,
  output logic [CNT_W-1:0]           MispredCnt
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam int GW    = GHR_BITS > 0 ? GHR_BITS : 1;
  logic [GW-1:0]    ghr;
  logic             upd, rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_target;
  ctr_t             rd_ctr;
  assign PredIdxF    = PCF[IDX+1:2] ^ (GHR_BITS > 0 ? IDX'(ghr) : '0);
  assign PredTakenF  = rd_valid && rd_tag == PCF[XLEN-1:IDX+2] && rd_ctr >= CTR_WT;
  assign PredTargetF = PredTakenF ? rd_target : PCF + XLEN'(4);
  assign upd         = UpdateE && !FlushE;
  assign MispredictE = upd && (PredTakenE != BranchTakenE || (BranchTakenE && PredTargetE != BranchTargetE));
  assign CorrectPCE  = BranchTakenE ? BranchTargetE : PCE + XLEN'(4);
  bp_table #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_INIT(CTR_INIT)) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (PredIdxF),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_target(rd_target),
    .rd_ctr   (rd_ctr),
    .wr_en    (upd),
    .wr_idx   (PredIdxE),
    .wr_tag   (PCE[XLEN-1:IDX+2]),
    .wr_taken (BranchTakenE),
    .wr_target(BranchTargetE)
  );
  // non-speculative global history, shifted only on resolved branches
  always_ff @(posedge clk or posedge reset)
    if (reset) ghr <= '0;
    else if (upd && GHR_BITS > 0) ghr <= GW'({ghr, BranchTakenE});
  // saturating misprediction counter
  always_ff @(posedge clk or posedge reset)
    if (reset) MispredCnt <= '0;
    else if (MispredictE && !(&MispredCnt)) MispredCnt <= MispredCnt + CNT_W'(1);
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the pipelined RV32 core.
- Replaces the current "predict not-taken, flush on PCSrcE" policy with a direct-mapped BTB and 2-bit saturating counters.
- Indexing is bimodal or gshare, selected by parameter.
- Lookup is combinational on PCF. Training uses Execute-stage resolution and is registered. The block also flags mispredictions and supplies the corrected PC to the hazard unit and the PC mux.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 64, BTB/BHT depth; power of two, minimum 4.
- GHR_BITS, 0, global history length; 0 = bimodal, otherwise gshare; must be ≤ log2(ENTRIES).
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).
- CNT_W, 32, width of the misprediction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- PCF  in  XLEN  fetch PC
- PredTakenF  out  1  predicted taken
- PredTargetF  out  XLEN  predicted next PC
- PredIdxF  out  log2(ENTRIES)  table index used for this lookup; pipelined down to E by the datapath
- UpdateE  in  1  E-stage instruction is a branch/jal/jalr
- FlushE  in  1  E-stage bubble; suppresses update and mispredict
- PCE  in  XLEN  E-stage PC
- PredIdxE  in  log2(ENTRIES)  pipelined PredIdxF
- PredTakenE  in  1  pipelined PredTakenF
- PredTargetE  in  XLEN  pipelined PredTargetF
- BranchTakenE  in  1  resolved direction (PCSrcE)
- BranchTargetE  in  XLEN  resolved target
- MispredictE  out  1  redirect required
- CorrectPCE  out  XLEN  redirect PC
- MispredCnt  out  CNT_W  saturating misprediction count

Behaviour:
- Clocking: single clock clk; reset asynchronous active-high.
- Reset values:
  - all valid bits = 0; counters = CTR_INIT; GHR = 0; MispredCnt = 0.
  - Consequence: PredTakenF = 0 and PredTargetF = PCF+4 immediately.
- Fields: IDX = log2(ENTRIES).
  - Index: PCF[IDX+1:2], XOR zero-extended GHR when GHR_BITS > 0.
  - Tag: PCF[XLEN-1:IDX+2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == PCF tag.
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = PredTakenF ? target[idx] : PCF+4, wrapping modulo 2^XLEN.
- Effective update: upd = UpdateE && !FlushE.
- Mispredict (combinational):
  - MispredictE = upd && ((PredTakenE != BranchTakenE) || (BranchTakenE && PredTargetE != BranchTargetE)).
  - CorrectPCE = BranchTakenE ? BranchTargetE : PCE+4. CorrectPCE is valid only when MispredictE = 1.
- Training on the clk edge when upd, at index PredIdxE:
  - Entry tag matches PCE tag: counter increments if taken, decrements if not, saturating at 3 and 0. If taken, target is rewritten with BranchTargetE.
  - Tag miss and taken: allocate the entry with valid = 1, tag = PCE tag, target = BranchTargetE, ctr = 2'b10.
  - Tag miss and not taken: no write.
  - GHR (when GHR_BITS > 0): shifts left, inserting BranchTakenE into bit 0. It updates at resolution only and is non-speculative.
  - MispredCnt increments when MispredictE = 1 and holds at all ones.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update state (no bypass). The write lands on the edge.
- reset asserted mid-operation: all state clears asynchronously; in-flight PredIdx values are discarded by the pipeline flush.
- No stall input: lookup depends only on PCF, so the PCF hold during StallF is transparent.

Decomposition:
- Shared package bp_pkg holds:
  - typedef ctr_t (logic [1:0]);
  - constants CTR_SNT = 0, CTR_WNT = 1, CTR_WT = 2, CTR_ST = 3;
  - function ctr_next(ctr_t, taken).
- One sub-module, bp_table: the valid/tag/target/ctr storage with one combinational read port, one synchronous write port, and async reset of valid and counters.
- Index/GHR logic, mispredict detection and the counter stay in branch_predictor.

Test Plan:
1. Reset then PCF = 0x100 → PredTakenF = 0, PredTargetF = 0x104, MispredCnt = 0.
2. Taken branch at PCE = 0x100 to 0x80 resolved with PredTakenE = 0 → MispredictE = 1, CorrectPCE = 0x80. Next cycle PCF = 0x100 → PredTakenF = 1, PredTargetF = 0x80, MispredCnt = 1.
3. Counter saturation: same branch resolved taken 4×, then not-taken 1× → still predicts taken (ctr 3→2). A second not-taken → PredTakenF = 0 (ctr 1).
4. Aliasing with ENTRIES = 64: PC 0x100 allocated, then PC 0x200 (same index, different tag) taken to 0x40 → lookup at 0x100 misses (PredTargetF = 0x104), lookup at 0x200 → 0x40.
5. FlushE = 1 with UpdateE = 1 and a wrong prediction → MispredictE = 0, table and MispredCnt unchanged.
6. GHR_BITS = 2: resolve T, T at other PCs, then lookup PCF = 0x100 → PredIdxF = (0x100>>2 & 63) ^ 3 = 0x03. Assert reset mid-run → PredTakenF = 0 and GHR = 0 in the same cycle.
